vdp_wr_queue: RTL and testbench
===============================

VDP_WR_QUEUE -- requirements
Module: vdp_wr_queue

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; power of two, at least 2.
REQ-002 Parameter ROW_W, default 4, sprite row-index width.
REQ-003 Parameter IDX_W, default 3, sprite-index width (8 sprites).
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 wr_valid  in  1  decoded sprite write from the AHB data phase.
REQ-007 wr_xy  in  1  1 = XY register write, 0 = row write.
REQ-008 wr_sprite  in  IDX_W  target sprite index.
REQ-009 wr_row  in  ROW_W  target row index; ignored when wr_xy = 1.
REQ-010 wr_data  in  32  write payload.
REQ-011 vblank  in  1  high while vpos >= V_DISPLAY, from the sync generator.
REQ-012 clr_overflow  in  1  clears the overflow flag.
REQ-013 wr_ready  out  1  equals !full; advisory only.
REQ-014 out_xy_we  out  1  one-cycle XY write strobe to the sprite array.
REQ-015 out_row_we  out  1  one-cycle row write strobe to the sprite array.
REQ-016 out_sprite, out_row, out_data  out  IDX_W/ROW_W/32  fields for the current strobe.
REQ-017 level  out  log2(DEPTH)+1  number of entries held.
REQ-018 overflow  out  1  sticky flag: a write was dropped.
REQ-019 frame_done  out  1  one-cycle pulse when a drain completes.

Function
REQ-020 Push: accepted when wr_valid=1 and full=0; the entry {xy, sprite, row, data} is stored at the write pointer, which then increments modulo DEPTH.
REQ-021 Push while full: the entry is dropped, the FIFO is unchanged, and overflow is set on the next edge.
REQ-022 The full decision uses registered state only; a pop in the same cycle does not make room for a push.
REQ-023 Simultaneous push and pop when not full: both take effect and level is unchanged.
REQ-024 Pointers carry an extra wrap bit: full = (pointers differ only in the MSB); empty = (pointers are equal).
REQ-025 FSM states: IDLE, DRAIN, DONE.
REQ-026 IDLE -> DRAIN on a vblank rising edge (registered vblank 0 -> 1) with level > 0; drain_cnt is loaded with level at that edge.
REQ-027 IDLE -> DONE on a vblank rising edge with level = 0; frame_done pulses.
REQ-028 DRAIN: one pop per cycle, drain_cnt decrements. Entries pushed during DRAIN are not counted; they are applied in the next frame.
REQ-029 DRAIN -> DONE when drain_cnt reaches 1 and that pop occurs; frame_done pulses in the cycle after the last pop.
REQ-030 DRAIN -> IDLE if vblank falls before drain_cnt reaches 0; the remaining entries are kept in order, and frame_done does not pulse.
REQ-031 DONE -> IDLE when vblank = 0.
REQ-032 Output strobes are registered: a pop in cycle N drives out_*_we and the output fields in cycle N+1.
REQ-033 out_xy_we = popped xy; out_row_we = !popped xy; the two are never high together, and both are 0 in cycles with no pop.
REQ-034 Output fields hold their last values when no strobe is active.
REQ-035 Entries are emitted strictly in push order.
REQ-036 clr_overflow has priority over a simultaneous overflow set; the flag is cleared.

Reset
REQ-037 On reset, the following clear immediately: pointers, level = 0, FSM = IDLE, registered vblank = 0, drain_cnt = 0, out_xy_we = 0, out_row_we = 0, output fields = 0, overflow = 0, frame_done = 0.
REQ-038 wr_ready = 1 after reset.
REQ-039 Reset during DRAIN discards all entries, and no strobe is issued after reset asserts.
REQ-040 FIFO storage needs no reset.

Verification
REQ-041 Push 3 writes (xy, sprite 2, data 0x00640032; row, sprite 5, row 7, 0xFFFF0000; row, sprite 0, row 0, 0x1), then raise vblank -> strobes on cycles 2, 3, 4 after the edge, in that order, with matching fields; frame_done on cycle 4; level = 0.
REQ-042 Push DEPTH+2 writes with vblank low -> level = 16; wr_ready = 0; overflow = 1 after the 17th push; the first 16 entries drain intact; clr_overflow -> overflow = 0.
REQ-043 8 entries queued, vblank high for 3 cycles -> 3 strobes, no frame_done, level = 5; the next vblank drains the remaining 5 in order.
REQ-044 Push 2 entries during DRAIN of 4 -> exactly 4 strobes this frame, level = 2 afterward; the 2 entries drain on the next vblank.
REQ-045 Assert reset mid-DRAIN with 6 entries -> strobes stop immediately; level = 0; the next vblank gives frame_done with no strobes.
REQ-046 Empty FIFO, vblank rising -> frame_done only, no strobes; vblank stays high -> no second frame_done until vblank falls and rises again.

Source files
------------

// File: rtl/vdp_wr_queue.sv
// Sprite write queue for the VDP.
// Sprite register writes arriving from the bus are buffered in a FIFO during
// active display. On each vertical-blank rising edge the entries queued at
// that moment are replayed to the sprite array, one strobe per cycle.
//
// state | meaning
// IDLE  | waiting for a vblank rising edge; pushes accumulate
// DRAIN | popping the entries counted at vblank entry, one per cycle
// DONE  | drain complete (frame_done pulsed); waiting for vblank to drop

module vdp_wr_queue #(
    parameter int DEPTH = 16,
    parameter int ROW_W = 4,
    parameter int IDX_W = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_wr_valid,
    input  logic                     i_wr_xy,
    input  logic [IDX_W-1:0]         i_wr_sprite,
    input  logic [ROW_W-1:0]         i_wr_row,
    input  logic [31:0]              i_wr_data,
    input  logic                     i_vblank,
    input  logic                     i_clr_overflow,
    output logic                     o_wr_ready,
    output logic                     o_out_xy_we,
    output logic                     o_out_row_we,
    output logic [IDX_W-1:0]         o_out_sprite,
    output logic [ROW_W-1:0]         o_out_row,
    output logic [31:0]              o_out_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow,
    output logic                     o_frame_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 1 + IDX_W + ROW_W + 32;
    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [EW-1:0]    r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [AW:0]      r_drain_cnt;
    logic [1:0]       r_state;
    logic             r_vblank;
    logic             r_overflow;
    logic             r_frame_done;
    logic             r_xy_we;
    logic             r_row_we;
    logic [IDX_W-1:0] r_sprite;
    logic [ROW_W-1:0] r_row;
    logic [31:0]      r_data;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_drop;
    logic             w_pop;
    logic             w_vb_rise;
    logic [AW:0]      w_level;
    logic [EW-1:0]    w_rd;

    // Full/empty come from registered pointers only, so a same-cycle pop
    // never opens room for a push.
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty   = (r_wptr == r_rptr);
    assign w_push    = i_wr_valid && !w_full;
    assign w_drop    = i_wr_valid && w_full;
    assign w_pop     = (r_state == S_DRAIN) && (r_drain_cnt != '0) && !w_empty;
    assign w_vb_rise = i_vblank && !r_vblank;
    assign w_level   = r_wptr - r_rptr;
    assign w_rd      = r_mem[r_rptr[AW-1:0]];

    assign o_wr_ready   = !w_full;
    assign o_level      = w_level;
    assign o_overflow   = r_overflow;
    assign o_frame_done = r_frame_done;
    assign o_out_xy_we  = r_xy_we;
    assign o_out_row_we = r_row_we;
    assign o_out_sprite = r_sprite;
    assign o_out_row    = r_row;
    assign o_out_data   = r_data;

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= {i_wr_xy, i_wr_sprite, i_wr_row, i_wr_data};
        end
    end

    // Write/read pointers with wrap bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + ONE;
            if (w_pop)  r_rptr <= r_rptr + ONE;
        end
    end

    // Sticky overflow flag; an explicit clear beats a same-cycle drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (i_clr_overflow) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // Frame sequencing: count entries at vblank entry, drain them, report done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_vblank     <= 1'b0;
            r_drain_cnt  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_vblank     <= i_vblank;
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_vb_rise) begin
                        if (w_level != '0) begin
                            r_state     <= S_DRAIN;
                            r_drain_cnt <= w_level;
                        end else begin
                            r_state      <= S_DONE;
                            r_frame_done <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop) r_drain_cnt <= r_drain_cnt - ONE;
                    // Finishing the last counted pop wins over a coincident vblank fall.
                    if (w_pop && r_drain_cnt == ONE) begin
                        r_state      <= S_DONE;
                        r_frame_done <= 1'b1;
                    end else if (!i_vblank) begin
                        r_state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    if (!i_vblank) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Registered write strobes and fields; fields hold between strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_xy_we  <= 1'b0;
            r_row_we <= 1'b0;
            r_sprite <= '0;
            r_row    <= '0;
            r_data   <= '0;
        end else if (w_pop) begin
            r_xy_we  <= w_rd[EW-1];
            r_row_we <= !w_rd[EW-1];
            r_sprite <= w_rd[ROW_W+32 +: IDX_W];
            r_row    <= w_rd[32 +: ROW_W];
            r_data   <= w_rd[31:0];
        end else begin
            r_xy_we  <= 1'b0;
            r_row_we <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vdp_wr_queue.sv
// Directed testbench for vdp_wr_queue: strobe order and timing, overflow,
// partial drains, pushes during drain, reset mid-drain and empty frames.

module tb_vdp_wr_queue;

    localparam int DEPTH = 16;
    localparam int ROW_W = 4;
    localparam int IDX_W = 3;

    logic             clk;
    logic             reset;
    logic             wr_valid;
    logic             wr_xy;
    logic [IDX_W-1:0] wr_sprite;
    logic [ROW_W-1:0] wr_row;
    logic [31:0]      wr_data;
    logic             vblank;
    logic             clr_overflow;
    logic             wr_ready;
    logic             xy_we;
    logic             row_we;
    logic [IDX_W-1:0] out_sprite;
    logic [ROW_W-1:0] out_row;
    logic [31:0]      out_data;
    logic [4:0]       level;
    logic             overflow;
    logic             frame_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fd_cnt = 0;
    int fd_cyc = -1;
    int both_hi = 0;
    int c0;

    logic             s_xy[$];
    logic [IDX_W-1:0] s_spr[$];
    logic [ROW_W-1:0] s_row[$];
    logic [31:0]      s_data[$];
    int               s_cyc[$];

    vdp_wr_queue #(.DEPTH(DEPTH), .ROW_W(ROW_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset),
        .i_wr_valid(wr_valid), .i_wr_xy(wr_xy), .i_wr_sprite(wr_sprite),
        .i_wr_row(wr_row), .i_wr_data(wr_data), .i_vblank(vblank),
        .i_clr_overflow(clr_overflow),
        .o_wr_ready(wr_ready), .o_out_xy_we(xy_we), .o_out_row_we(row_we),
        .o_out_sprite(out_sprite), .o_out_row(out_row), .o_out_data(out_data),
        .o_level(level), .o_overflow(overflow), .o_frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Record every strobe and frame_done pulse seen mid-cycle.
    always @(negedge clk) begin
        if (xy_we || row_we) begin
            s_xy.push_back(xy_we);
            s_spr.push_back(out_sprite);
            s_row.push_back(out_row);
            s_data.push_back(out_data);
            s_cyc.push_back(cyc);
        end
        if (xy_we && row_we) both_hi++;
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        s_xy.delete(); s_spr.delete(); s_row.delete(); s_data.delete(); s_cyc.delete();
        fd_cnt = 0;
        fd_cyc = -1;
    endtask

    task automatic push(input logic xy, input logic [IDX_W-1:0] spr,
                        input logic [ROW_W-1:0] row, input logic [31:0] data);
        wr_valid = 1'b1; wr_xy = xy; wr_sprite = spr; wr_row = row; wr_data = data;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        if (level !== 5'd0)    begin errors++; $display("FAIL reset_level got %0d want 0", level); end
        checks++;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", wr_ready); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        checks++;
        if ({xy_we, row_we} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b want 00", {xy_we, row_we}); end
        checks++;
        if (out_data !== 32'd0 || out_sprite !== 3'd0 || out_row !== 4'd0) begin
            errors++; $display("FAIL reset_fields got %h/%0d/%0d want 0/0/0", out_data, out_sprite, out_row);
        end
        checks++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic_drain();
        logic        e_xy[3]   = '{1'b1, 1'b0, 1'b0};
        logic [2:0]  e_spr[3]  = '{3'd2, 3'd5, 3'd0};
        logic [3:0]  e_row[3]  = '{4'd0, 4'd7, 4'd0};
        logic [31:0] e_dat[3]  = '{32'h0064_0032, 32'hFFFF_0000, 32'h0000_0001};
        clear_log();
        push(1'b1, 3'd2, 4'd0, 32'h0064_0032);
        push(1'b0, 3'd5, 4'd7, 32'hFFFF_0000);
        push(1'b0, 3'd0, 4'd0, 32'h0000_0001);
        if (level !== 5'd3) begin errors++; $display("FAIL basic_level_before got %0d want 3", level); end
        checks++;
        vblank = 1'b1;
        c0 = cyc;
        step(7);
        if (s_data.size() !== 3) begin errors++; $display("FAIL basic_strobe_count got %0d want 3", s_data.size()); end
        checks++;
        for (int i = 0; i < 3 && i < s_data.size(); i++) begin
            if (s_cyc[i] !== c0 + 2 + i) begin errors++; $display("FAIL basic_strobe_cycle[%0d] got %0d want %0d", i, s_cyc[i] - c0, 2 + i); end
            checks++;
            if (s_xy[i] !== e_xy[i] || s_spr[i] !== e_spr[i] || s_data[i] !== e_dat[i]) begin
                errors++; $display("FAIL basic_fields[%0d] got xy%b spr%0d %h want xy%b spr%0d %h",
                                   i, s_xy[i], s_spr[i], s_data[i], e_xy[i], e_spr[i], e_dat[i]);
            end
            checks++;
            if (!e_xy[i] && s_row[i] !== e_row[i]) begin errors++; $display("FAIL basic_row[%0d] got %0d want %0d", i, s_row[i], e_row[i]); end
            checks++;
        end
        if (fd_cnt !== 1 || fd_cyc !== c0 + 4) begin
            errors++; $display("FAIL basic_frame_done got cnt %0d cycle %0d want cnt 1 cycle 4", fd_cnt, fd_cyc - c0);
        end
        checks++;
        if (level !== 5'd0) begin errors++; $display("FAIL basic_level_after got %0d want 0", level); end
        checks++;
        if (out_data !== 32'h0000_0001) begin errors++; $display("FAIL basic_field_hold got %h want 00000001", out_data); end
        checks++;
        vblank = 1'b0;
        step(2);
    endtask

    task automatic test_overflow();
        clear_log();
        for (int i = 0; i < DEPTH + 2; i++) begin
            push(i[0], i[2:0], i[3:0], 32'h100 + i);
            if (i == DEPTH - 1) begin
                if (level !== 5'd16 || wr_ready !== 1'b0 || overflow !== 1'b0) begin
                    errors++; $display("FAIL ovf_full got lvl %0d rdy %b ovf %b want 16 0 0", level, wr_ready, overflow);
                end
                checks++;
            end
            if (i == DEPTH) begin
                if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
                checks++;
            end
        end
        if (level !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d want 16", level); end
        checks++;
        clr_overflow = 1'b1;
        push(1'b0, 3'd7, 4'd15, 32'hDEAD_BEEF);
        clr_overflow = 1'b0;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr_priority got %b want 0", overflow); end
        checks++;
        push(1'b0, 3'd7, 4'd15, 32'hDEAD_BEEF);
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_reset_again got %b want 1", overflow); end
        checks++;
        vblank = 1'b1;
        step(22);
        if (s_data.size() !== 16) begin errors++; $display("FAIL ovf_drain_count got %0d want 16", s_data.size()); end
        checks++;
        for (int i = 0; i < 16 && i < s_data.size(); i++) begin
            if (s_data[i] !== 32'h100 + i || s_xy[i] !== i[0] || s_spr[i] !== i[2:0]) begin
                errors++; $display("FAIL ovf_drain[%0d] got %h xy%b spr%0d want %h", i, s_data[i], s_xy[i], s_spr[i], 32'h100 + i);
            end
            checks++;
        end
        if (level !== 5'd0 || fd_cnt !== 1) begin errors++; $display("FAIL ovf_after got lvl %0d fd %0d want 0 1", level, fd_cnt); end
        checks++;
        vblank = 1'b0;
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overflow); end
        checks++;
        step();
    endtask

    task automatic test_partial_drain();
        clear_log();
        for (int i = 0; i < 8; i++) push(1'b0, 3'd1, i[3:0], 32'h200 + i);
        vblank = 1'b1;
        step(3);
        vblank = 1'b0;
        step(5);
        if (s_data.size() !== 3 || fd_cnt !== 0 || level !== 5'd5) begin
            errors++; $display("FAIL partial_first got strobes %0d fd %0d lvl %0d want 3 0 5", s_data.size(), fd_cnt, level);
        end
        checks++;
        vblank = 1'b1;
        step(10);
        if (s_data.size() !== 8 || fd_cnt !== 1 || level !== 5'd0) begin
            errors++; $display("FAIL partial_second got strobes %0d fd %0d lvl %0d want 8 1 0", s_data.size(), fd_cnt, level);
        end
        checks++;
        for (int i = 0; i < 8 && i < s_data.size(); i++) begin
            if (s_data[i] !== 32'h200 + i || s_row[i] !== i[3:0]) begin
                errors++; $display("FAIL partial_order[%0d] got %h row %0d want %h", i, s_data[i], s_row[i], 32'h200 + i);
            end
            checks++;
        end
        vblank = 1'b0;
        step(2);
    endtask

    task automatic test_push_during_drain();
        clear_log();
        for (int i = 0; i < 4; i++) push(1'b1, i[2:0], 4'd0, 32'h300 + i);
        vblank = 1'b1;
        push(1'b0, 3'd6, 4'd2, 32'h310);
        push(1'b0, 3'd6, 4'd3, 32'h311);
        step(8);
        if (s_data.size() !== 4 || level !== 5'd2 || fd_cnt !== 1) begin
            errors++; $display("FAIL pdd_frame got strobes %0d lvl %0d fd %0d want 4 2 1", s_data.size(), level, fd_cnt);
        end
        checks++;
        vblank = 1'b0;
        step(2);
        vblank = 1'b1;
        step(6);
        if (s_data.size() !== 6 || level !== 5'd0) begin
            errors++; $display("FAIL pdd_next got strobes %0d lvl %0d want 6 0", s_data.size(), level);
        end
        checks++;
        for (int i = 0; i < 6 && i < s_data.size(); i++) begin
            if (s_data[i] !== ((i < 4) ? 32'h300 + i : 32'h30C + i)) begin
                errors++; $display("FAIL pdd_order[%0d] got %h want %h", i, s_data[i], (i < 4) ? 32'h300 + i : 32'h30C + i);
            end
            checks++;
        end
        vblank = 1'b0;
        step(2);
    endtask

    task automatic test_reset_mid_drain();
        clear_log();
        for (int i = 0; i < 6; i++) push(1'b0, 3'd3, i[3:0], 32'h400 + i);
        vblank = 1'b1;
        step(3);
        reset = 1'b1;
        vblank = 1'b0;
        #1;
        if ({xy_we, row_we} !== 2'b00 || level !== 5'd0) begin
            errors++; $display("FAIL rst_drain_now got we %b lvl %0d want 00 0", {xy_we, row_we}, level);
        end
        checks++;
        step(2);
        reset = 1'b0;
        step();
        vblank = 1'b1;
        step(5);
        if (s_data.size() !== 1 || fd_cnt !== 1 || level !== 5'd0) begin
            errors++; $display("FAIL rst_drain_after got strobes %0d fd %0d lvl %0d want 1 1 0", s_data.size(), fd_cnt, level);
        end
        checks++;
        if (s_data.size() > 0 && s_data[0] !== 32'h400) begin
            errors++; $display("FAIL rst_drain_first got %h want 00000400", s_data[0]);
        end
        checks++;
        vblank = 1'b0;
        step(2);
    endtask

    task automatic test_empty_vblank();
        clear_log();
        vblank = 1'b1;
        c0 = cyc;
        step(6);
        if (fd_cnt !== 1 || fd_cyc !== c0 + 1 || s_data.size() !== 0) begin
            errors++; $display("FAIL empty_first got fd %0d at %0d strobes %0d want 1 at 1 0", fd_cnt, fd_cyc - c0, s_data.size());
        end
        checks++;
        vblank = 1'b0;
        step(2);
        if (fd_cnt !== 1) begin errors++; $display("FAIL empty_no_repeat got %0d want 1", fd_cnt); end
        checks++;
        vblank = 1'b1;
        step(3);
        if (fd_cnt !== 2 || s_data.size() !== 0) begin
            errors++; $display("FAIL empty_second got fd %0d strobes %0d want 2 0", fd_cnt, s_data.size());
        end
        checks++;
        vblank = 1'b0;
        step(2);
    endtask

    initial begin
        reset = 1'b1; wr_valid = 1'b0; wr_xy = 1'b0; wr_sprite = '0; wr_row = '0;
        wr_data = '0; vblank = 1'b0; clr_overflow = 1'b0;
        test_reset();
        test_basic_drain();
        test_overflow();
        test_partial_drain();
        test_push_during_drain();
        test_reset_mid_drain();
        test_empty_vblank();
        if (both_hi !== 0) begin errors++; $display("FAIL both_strobes got %0d cycles want 0", both_hi); end
        checks++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
